// File: rtl/mem_port_arbiter3_pkg.sv
// Shared definitions for the three-port memory arbiter: MUX3 select codes,
// FSM state encoding and the round-robin index helpers.
package mem_port_arbiter3_pkg;

    // MUX3 select codes, shared with every user of the steering mux
    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    // Next requester index in circular order 0 -> 1 -> 2 -> 0
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // One-hot grant vector for a select code; idle maps to no grant
    function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_REQ0: oh = 3'b001;
            SEL_REQ1: oh = 3'b010;
            SEL_REQ2: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter3_rr_pick3.sv
// Combinational round-robin pick among three requesters, starting the search at ptr.
module mem_port_arbiter3_rr_pick3
    import mem_port_arbiter3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx,
    output logic [2:0] onehot
);

    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    // Search order ptr, ptr+1, ptr+2 (mod 3); an illegal ptr of 3 behaves as 0
    always_comb begin
        p0     = (ptr == 2'd3) ? 2'd0 : ptr;
        p1     = rr_next(p0);
        p2     = rr_next(p1);
        any    = |req;
        idx    = SEL_IDLE;
        if (req[p0]) begin
            idx = p0;
        end else if (req[p1]) begin
            idx = p1;
        end else if (req[p2]) begin
            idx = p2;
        end
        onehot = sel_to_onehot(idx);
    end

endmodule

// File: rtl/mem_port_arbiter3.sv
// Round-robin arbiter for one shared 32-bit memory port (fetch, load/store, debug).
// Holds a grant for a whole transaction, supports lock for atomic sequences and
// frees a hung port through a watchdog. All outputs come straight from registers.
module mem_port_arbiter3
    import mem_port_arbiter3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic       mem_ack,
    input  logic       err_clr,
    output logic [2:0] gnt,
    output logic [1:0] mux_sel,
    output logic       mem_valid,
    output logic       busy,
    output logic       timeout_err
);

    // Last watchdog value before a forced release; unused when TIMEOUT_CYC is 0
    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e       state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       mux_sel_q, mux_sel_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             timeout_err_q, timeout_err_d;

    logic       pick_any;
    logic [1:0] pick_idx;
    logic [2:0] pick_onehot;
    logic       release_port;
    logic       timeout_set;
    logic       timeout_hit;

    mem_port_arbiter3_rr_pick3 u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) && (wdog_q == WdogLast);

    // Next-state logic: grant from IDLE, hold/release in BUSY, sticky error flag
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        mux_sel_d     = mux_sel_q;
        rr_ptr_d      = rr_ptr_q;
        wdog_d        = wdog_q;
        release_port  = 1'b0;
        timeout_set   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d   = StBusy;
                    gnt_d     = pick_onehot;
                    mux_sel_d = pick_idx;
                    wdog_d    = '0;
                end
            end
            StBusy: begin
                // Ack has priority over both abort and timeout
                if (mem_ack) begin
                    if (lock[mux_sel_q] && req[mux_sel_q]) begin
                        wdog_d = '0;
                    end else begin
                        release_port = 1'b1;
                    end
                end else if (!req[mux_sel_q]) begin
                    release_port = 1'b1;
                end else if (timeout_hit) begin
                    release_port = 1'b1;
                    timeout_set  = 1'b1;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
        endcase

        if (release_port) begin
            state_d   = StIdle;
            gnt_d     = 3'b000;
            mux_sel_d = SEL_IDLE;
            rr_ptr_d  = rr_next(mux_sel_q);
            wdog_d    = '0;
        end

        // A new timeout beats a simultaneous clear
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            gnt_q         <= 3'b000;
            mux_sel_q     <= SEL_IDLE;
            rr_ptr_q      <= 2'd0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            mux_sel_q     <= mux_sel_d;
            rr_ptr_q      <= rr_ptr_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign mux_sel     = mux_sel_q;
    assign mem_valid   = |gnt_q;
    assign busy        = (state_q == StBusy);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Bench for mem_port_arbiter3: directed stimulus, a transaction-level model checked
// every cycle, and literal expectations at key points of each scenario.
module tb_mem_port_arbiter3;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] lock;
    logic       mem_ack;
    logic       err_clr;
    logic [2:0] gnt;
    logic [1:0] mux_sel;
    logic       mem_valid;
    logic       busy;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    // Model: granted index (-1 = none), priority pointer, watchdog age, sticky error
    int m_g;
    int m_ptr;
    int m_wdog;
    bit m_err;
    bit model_live = 1'b0;

    mem_port_arbiter3 #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .lock        (lock),
        .mem_ack     (mem_ack),
        .err_clr     (err_clr),
        .gnt         (gnt),
        .mux_sel     (mux_sel),
        .mem_valid   (mem_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs seen at this edge
    always @(posedge clk) begin : model
        bit set_err;
        int c;
        set_err = 1'b0;
        if (!rst_n) begin
            m_g    = -1;
            m_ptr  = 0;
            m_wdog = 0;
            m_err  = 1'b0;
        end else begin
            if (m_g < 0) begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_ptr + k) % 3;
                    if (m_g < 0 && req[c]) begin
                        m_g    = c;
                        m_wdog = 0;
                    end
                end
            end else if (mem_ack) begin
                if (lock[m_g] && req[m_g]) begin
                    m_wdog = 0;
                end else begin
                    m_ptr = (m_g + 1) % 3;
                    m_g   = -1;
                end
            end else if (!req[m_g]) begin
                m_ptr = (m_g + 1) % 3;
                m_g   = -1;
            end else if (TO != 0 && m_wdog == int'(TO) - 1) begin
                m_ptr   = (m_g + 1) % 3;
                m_g     = -1;
                set_err = 1'b1;
            end else begin
                m_wdog = m_wdog + 1;
            end
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        model_live = 1'b1;
    end

    // Compare every DUT output to the model half a cycle after each edge
    always @(negedge clk) begin
        logic [2:0] eg;
        logic [1:0] em;
        logic       ev;
        if (model_live) begin
            eg = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
            em = (m_g < 0) ? 2'b11 : 2'(m_g);
            ev = (m_g >= 0);
            vectors++;
            if (gnt !== eg || mux_sel !== em || mem_valid !== ev || busy !== ev ||
                timeout_err !== m_err) begin
                miscompares++;
                $display("FAIL model t=%0t: got gnt=%b sel=%b valid=%b busy=%b err=%b, want gnt=%b sel=%b valid=%b busy=%b err=%b",
                         $time, gnt, mux_sel, mem_valid, busy, timeout_err,
                         eg, em, ev, ev, m_err);
            end
        end
    end

    // Literal check of {gnt, mux_sel, mem_valid, busy, timeout_err}
    task automatic lit(input string name, input logic [7:0] want);
        logic [7:0] got;
        got = {gnt, mux_sel, mem_valid, busy, timeout_err};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got gnt/sel/v/b/e=%b want %b", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_g [3];
    logic [1:0] rr_m [3];

    initial begin
        rr_g = '{3'b010, 3'b100, 3'b001};
        rr_m = '{2'b01, 2'b10, 2'b00};

        // Reset with all requests pending
        rst_n = 1'b0; req = 3'b111; lock = 3'b000; mem_ack = 1'b0; err_clr = 1'b0;
        step(3);
        lit("reset_vals", 8'b000_11_000);
        rst_n = 1'b1;
        step(1);
        lit("first_grant", 8'b001_00_110);

        // Round-robin 0 -> 1 -> 2 -> 0 with a one-cycle idle gap
        for (int i = 0; i < 3; i++) begin
            step(2);
            mem_ack = 1'b1;
            step(1);
            mem_ack = 1'b0;
            lit("rr_gap", 8'b000_11_000);
            step(1);
            lit("rr_grant", {rr_g[i], rr_m[i], 3'b110});
        end

        // Lock keeps requester 0 across three acks
        req = 3'b011; lock = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step(1);
            mem_ack = 1'b1;
            step(1);
            mem_ack = 1'b0;
            lit("lock_hold", 8'b001_00_110);
        end
        lock = 3'b000;
        step(1);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        lit("unlock_idle", 8'b000_11_000);
        step(1);
        lit("unlock_next", 8'b010_01_110);
        mem_ack = 1'b1; req = 3'b000;
        step(1);
        mem_ack = 1'b0;
        step(2);

        // Watchdog: no ack for four busy cycles
        req = 3'b100;
        step(1);
        lit("wd_grant", 8'b100_10_110);
        step(3);
        lit("wd_still_busy", 8'b100_10_110);
        step(1);
        lit("wd_timeout", 8'b000_11_001);
        req = 3'b000;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        lit("wd_err_clr", 8'b000_11_000);

        // Ack lands on the timeout cycle: no error
        req = 3'b100;
        step(1);
        step(3);
        mem_ack = 1'b1; req = 3'b000;
        step(1);
        mem_ack = 1'b0;
        lit("wd_ack_wins", 8'b000_11_000);

        // Timeout and err_clr together: the flag is set
        req = 3'b100;
        step(4);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0; req = 3'b000;
        lit("wd_set_wins", 8'b000_11_001);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        lit("wd_clr_again", 8'b000_11_000);

        // Abort: requester 1 drops before ack, pointer moves to 2
        req = 3'b010;
        step(1);
        lit("abort_grant", 8'b010_01_110);
        req = 3'b101;
        step(1);
        lit("abort_idle", 8'b000_11_000);
        step(1);
        lit("abort_next_req2", 8'b100_10_110);

        // Reset while busy, then pointer must be back at 0
        rst_n = 1'b0;
        step(1);
        lit("midreset", 8'b000_11_000);
        rst_n = 1'b1; req = 3'b111;
        step(1);
        lit("post_reset_grant", 8'b001_00_110);

        // Locks from non-granted requesters do not hold the grant
        lock = 3'b110;
        step(1);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        lit("foreign_lock", 8'b000_11_000);
        lock = 3'b000; req = 3'b000;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
